wash_cycle_ctrl: RTL and testbench
==================================

Name: wash_cycle_ctrl

Overview:
Second-generation coin-operated wash controller that merges the cycle state machine and the duration timer into one parametrised block. It runs a configurable sequence of FILL, WASH and RINSE passes followed by one SPIN, sized by per-stage tick parameters. It has a selectable prescaler, pause-during-spin and status outputs. It sits at the top of the washing-machine controller and replaces the fixed single/double-wash pair.

Parameters:
BASE_DIV, 60, CLK cycles per tick when CLK_freq=0; tick period = BASE_DIV << CLK_freq cycles
DIV_W, 10, prescaler counter width; must hold (BASE_DIV<<3)-1
FILL_TICKS, 2, ticks spent in FILL (>=1)
WASH_TICKS, 5, ticks spent in WASH (>=1)
RINSE_TICKS, 2, ticks spent in RINSE (>=1)
SPIN_TICKS, 1, ticks spent in SPIN (>=1)
TICK_W, 8, stage tick counter width; must hold max stage ticks
MAX_PASSES, 3, upper clamp on requested passes
PASS_W, 2, width of Wash_passes / Pass_cnt

Ports:
CLK  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Coin_in  in  1  start request; sampled high in IDLE starts a cycle
Wash_passes  in  PASS_W  number of FILL/WASH/RINSE passes; sampled with the coin
Timer_pause  in  1  pause request; honoured only in SPIN
CLK_freq  in  2  prescaler select; sampled with the coin
Wash_done  out  1  high while in IDLE
Done_pulse  out  1  one-cycle pulse on SPIN completion
Busy  out  1  inverse of Wash_done
Stage  out  3  current state encoding
Pass_cnt  out  PASS_W  index of current pass, 0-based

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, latched passes/freq 0, Wash_done=1, Busy=0, Done_pulse=0, Stage=IDLE, Pass_cnt=0.
- States: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4. Codes 5-7 are illegal and recover to IDLE on the next cycle.
- IDLE: Coin_in=1 at edge n -> FILL at edge n+1 (Wash_done falls after 1 cycle).
  - Latch CLK_freq.
  - Latch passes = clamp(Wash_passes, 1, MAX_PASSES); 0 maps to 1.
  - Clear Pass_cnt, prescaler and tick counter.
- Coin_in outside IDLE is ignored. No queuing.
- Tick generation:
  - The prescaler counts 0..(BASE_DIV<<freq_lat)-1.
  - tick=1 in the cycle it equals its terminal value; it then wraps to 0.
  - The tick counter increments on tick.
- Stage exit: taken on the cycle where tick=1 and tick counter = STAGE_TICKS-1.
  - Prescaler and tick counter clear on every stage entry.
  - Each stage therefore lasts exactly STAGE_TICKS*(BASE_DIV<<freq_lat) unpaused cycles.
- Transitions:
  - FILL->WASH, WASH->RINSE.
  - RINSE->FILL if Pass_cnt < passes-1; Pass_cnt increments on this transition.
  - Otherwise RINSE->SPIN.
  - SPIN->IDLE with Done_pulse=1 for the first IDLE cycle.
- Pause: Timer_pause=1 in SPIN freezes the prescaler and tick counter; the freeze is effective the same cycle, with no tick. Release resumes from the frozen count. Timer_pause is ignored in all other states, and a pause held at entry to SPIN freezes from the first SPIN cycle.
- Pause and final tick in the same cycle: pause wins, so there is no exit.
- Mid-cycle changes to CLK_freq or Wash_passes have no effect until the next coin.
- Reset asserted mid-operation aborts immediately to reset values. No resume.
- Outputs are registered or decoded from registered state only, with no input-to-output combinational path.

Decomposition:
- Package wash_pkg: state enum (IDLE..SPIN, 3-bit), a stage-to-duration function mapping state to its TICKS parameter, and a localparam for the maximum prescale.
- Sub-module wash_tick_gen:
  - Contents: prescaler plus stage tick counter.
  - Inputs: CLK, Rst_n, clr, hold, freq_sel, target_ticks.
  - Outputs: tick, stage_end.
- The FSM remains in wash_cycle_ctrl.

Test Plan:
- BASE_DIV=4, ticks 2/3/2/1, CLK_freq=0, Wash_passes=1, coin pulse at cycle 0 -> FILL at cycle 1. Stages last 8/12/8/4 cycles, IDLE at cycle 33, and Done_pulse is asserted at cycle 33 only.
- Same setup with Wash_passes=2 -> Pass_cnt goes 0→1 at the first RINSE exit. Total busy time is (7*2+1)*4=60 cycles.
- Same setup with CLK_freq=2 -> every stage is 4x longer, 128 busy cycles. Changing CLK_freq to 0 mid-WASH has no effect.
- Single pass, Timer_pause high for 10 cycles in SPIN, plus a 5-cycle pause during WASH -> only the SPIN pause counts, so completion is delayed by exactly 10 cycles (IDLE at cycle 43).
- Coin re-pulsed in WASH -> ignored. Rst_n low mid-RINSE -> immediate IDLE with Wash_done=1 and Pass_cnt=0, and no Done_pulse.
- Wash_passes=0 -> one pass. Wash_passes=3 with MAX_PASSES=2 -> exactly two passes.

Source files
------------

// File: rtl/wash_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wash_pkg
// Description : Shared state encoding and helpers for the wash cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4
    } wash_state_t;

    // Largest prescaler shift selectable through the 2-bit frequency input.
    localparam int unsigned c_MAX_PRESCALE = 3;

    function automatic int unsigned stage_ticks(
        input wash_state_t st,
        input int unsigned fill_t,
        input int unsigned wash_t,
        input int unsigned rinse_t,
        input int unsigned spin_t
    );
        case (st)
            FILL:    return fill_t;
            WASH:    return wash_t;
            RINSE:   return rinse_t;
            SPIN:    return spin_t;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned clamp_passes(
        input int unsigned req,
        input int unsigned max_p
    );
        if (req == 0)    return 1;
        if (req > max_p) return max_p;
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_ctrl_if
// Description : Request/status bundle between a cycle requester and the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface wash_cycle_ctrl_if #(
    parameter int PASS_W = 2
);
    logic              Coin_in;
    logic [PASS_W-1:0] Wash_passes;
    logic              Timer_pause;
    logic [1:0]        CLK_freq;
    logic              Wash_done;
    logic              Done_pulse;
    logic              Busy;
    logic [2:0]        Stage;
    logic [PASS_W-1:0] Pass_cnt;

    modport master (
        output Coin_in, Wash_passes, Timer_pause, CLK_freq,
        input  Wash_done, Done_pulse, Busy, Stage, Pass_cnt
    );

    modport slave (
        input  Coin_in, Wash_passes, Timer_pause, CLK_freq,
        output Wash_done, Done_pulse, Busy, Stage, Pass_cnt
    );
endinterface
`default_nettype wire

// File: rtl/wash_cycle_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : wash_tick_gen
// Description : Selectable prescaler plus per-stage tick counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_tick_gen #(
    parameter int BASE_DIV = 60,
    parameter int DIV_W    = 10,
    parameter int TICK_W   = 8
) (
    input  wire logic              CLK,
    input  wire logic              Rst_n,
    input  wire logic              clr,
    input  wire logic              hold,
    input  wire logic [1:0]        freq_sel,
    input  wire logic [TICK_W-1:0] target_ticks,
    output logic                   tick,
    output logic                   stage_end
);
    localparam logic [DIV_W-1:0] c_BASE = DIV_W'(BASE_DIV);

    logic [DIV_W-1:0]  r_div;
    logic [TICK_W-1:0] r_ticks;
    logic [DIV_W-1:0]  w_term;

    // Terminal count of the prescaler: (BASE_DIV << freq_sel) - 1.
    assign w_term = (c_BASE << freq_sel) - DIV_W'(1);

    // A held timer never ticks, so a pause always beats the final tick.
    assign tick      = (r_div == w_term) && !hold;
    // Level flag: the tick counter sits on the last tick of the stage.
    assign stage_end = (r_ticks == (target_ticks - TICK_W'(1)));

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_div   <= '0;
            r_ticks <= '0;
        end else if (clr) begin
            r_div   <= '0;
            r_ticks <= '0;
        end else if (!hold) begin
            if (tick) begin
                r_div   <= '0;
                r_ticks <= r_ticks + TICK_W'(1);
            end else begin
                r_div   <= r_div + DIV_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_ctrl
// Description : Coin-operated FILL/WASH/RINSE x N + SPIN cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int BASE_DIV    = 60,
    parameter int DIV_W       = 10,
    parameter int FILL_TICKS  = 2,
    parameter int WASH_TICKS  = 5,
    parameter int RINSE_TICKS = 2,
    parameter int SPIN_TICKS  = 1,
    parameter int TICK_W      = 8,
    parameter int MAX_PASSES  = 3,
    parameter int PASS_W      = 2
) (
    input  wire logic       CLK,
    input  wire logic       Rst_n,
    wash_cycle_ctrl_if.slave bus
);
    wash_state_t       r_state;
    logic [PASS_W-1:0] r_passes;
    logic [PASS_W-1:0] r_pass_cnt;
    logic [1:0]        r_freq;
    logic              r_done_pulse;

    logic              w_tick;
    logic              w_stage_end;
    logic              w_exit;
    logic              w_hold;
    logic              w_clr;
    logic [TICK_W-1:0] w_target;

    assign w_hold   = (r_state == SPIN) && bus.Timer_pause;
    assign w_exit   = w_tick && w_stage_end;
    // Idle keeps the timer parked at zero, so a coin always starts FILL clean.
    assign w_clr    = w_exit || (r_state == IDLE);
    assign w_target = TICK_W'(stage_ticks(r_state, FILL_TICKS, WASH_TICKS,
                                          RINSE_TICKS, SPIN_TICKS));

    wash_tick_gen #(
        .BASE_DIV (BASE_DIV),
        .DIV_W    (DIV_W),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .CLK          (CLK),
        .Rst_n        (Rst_n),
        .clr          (w_clr),
        .hold         (w_hold),
        .freq_sel     (r_freq),
        .target_ticks (w_target),
        .tick         (w_tick),
        .stage_end    (w_stage_end)
    );

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= IDLE;
            r_passes     <= '0;
            r_pass_cnt   <= '0;
            r_freq       <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Coin_in) begin
                        r_state    <= FILL;
                        r_freq     <= bus.CLK_freq;
                        r_passes   <= PASS_W'(clamp_passes(32'(bus.Wash_passes),
                                                           MAX_PASSES));
                        r_pass_cnt <= '0;
                    end
                end
                FILL: begin
                    if (w_exit) r_state <= WASH;
                end
                WASH: begin
                    if (w_exit) r_state <= RINSE;
                end
                RINSE: begin
                    if (w_exit) begin
                        if (r_pass_cnt < (r_passes - PASS_W'(1))) begin
                            r_state    <= FILL;
                            r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                        end else begin
                            r_state    <= SPIN;
                        end
                    end
                end
                SPIN: begin
                    if (w_exit) begin
                        r_state      <= IDLE;
                        r_done_pulse <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Wash_done  = (r_state == IDLE);
    assign bus.Busy       = (r_state != IDLE);
    assign bus.Done_pulse = r_done_pulse;
    assign bus.Stage      = r_state;
    assign bus.Pass_cnt   = r_pass_cnt;
endmodule
`default_nettype wire

// File: tb/tb_wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_cycle_ctrl
// Description : Scoreboard bench; expected stage transitions are queued up front.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_cycle_ctrl;
    import wash_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wash_cycle_ctrl_if #(.PASS_W(2)) if_a ();
    wash_cycle_ctrl_if #(.PASS_W(2)) if_b ();

    wash_cycle_ctrl #(
        .BASE_DIV(4), .DIV_W(6), .FILL_TICKS(2), .WASH_TICKS(3),
        .RINSE_TICKS(2), .SPIN_TICKS(1), .TICK_W(4), .MAX_PASSES(3), .PASS_W(2)
    ) dut_a (.CLK(clk), .Rst_n(rst_n), .bus(if_a));

    wash_cycle_ctrl #(
        .BASE_DIV(4), .DIV_W(6), .FILL_TICKS(2), .WASH_TICKS(3),
        .RINSE_TICKS(2), .SPIN_TICKS(1), .TICK_W(4), .MAX_PASSES(2), .PASS_W(2)
    ) dut_b (.CLK(clk), .Rst_n(rst_n), .bus(if_b));

    typedef struct {
        bit         inst;
        logic [2:0] st;
        logic [1:0] pc;
        logic       dp;
        int         cyc;
    } rec_t;

    rec_t       exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         g_cyc   = 0;
    int         c0;
    logic [2:0] prev_a  = 3'd0;
    logic [2:0] prev_b  = 3'd0;

    always @(posedge clk) g_cyc <= g_cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, g_cyc);
    endtask

    task automatic push_one(input bit inst, input logic [2:0] st, input int pc,
                            input bit dp, input int cyc);
        rec_t r;
        r.inst = inst; r.st = st; r.pc = 2'(pc); r.dp = dp; r.cyc = cyc;
        exp_q.push_back(r);
    endtask

    // Stage lengths in ticks are 2/3/2/1; p is cycles per tick.
    task automatic push_seq(input bit inst, input int start, input int n,
                            input int p, input int spin_extra);
        int t = start + 1;
        for (int k = 0; k < n; k++) begin
            push_one(inst, FILL,  k, 1'b0, t);
            push_one(inst, WASH,  k, 1'b0, t + 2 * p);
            push_one(inst, RINSE, k, 1'b0, t + 5 * p);
            t = t + 7 * p;
        end
        push_one(inst, SPIN, n - 1, 1'b0, t);
        push_one(inst, IDLE, n - 1, 1'b1, t + p + spin_extra);
    endtask

    task automatic ev_check(input bit inst, input logic [2:0] st, input logic [1:0] pc,
                            input logic dp, input logic wd, input logic bz,
                            input logic [2:0] prev);
        rec_t r;
        if (st != prev) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_transition: inst %0d stage %0d at cycle %0d, none expected",
                         inst, st, g_cyc);
            end else begin
                r = exp_q.pop_front();
                chk("event_inst", int'(inst), int'(r.inst));
                chk("stage",      int'(st),   int'(r.st));
                chk("pass_cnt",   int'(pc),   int'(r.pc));
                chk("done_pulse", int'(dp),   int'(r.dp));
                chk("event_cycle", g_cyc,     r.cyc);
                chk("wash_done",  int'(wd),   (r.st == IDLE) ? 1 : 0);
                chk("busy",       int'(bz),   (r.st == IDLE) ? 0 : 1);
            end
        end else if (dp) begin
            n_total++;
            $display("FAIL stray_done_pulse: inst %0d Done_pulse=1 without transition at cycle %0d, expected 0",
                     inst, g_cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_check(1'b0, if_a.Stage, if_a.Pass_cnt, if_a.Done_pulse, if_a.Wash_done, if_a.Busy, prev_a);
        prev_a = if_a.Stage;
        ev_check(1'b1, if_b.Stage, if_b.Pass_cnt, if_b.Done_pulse, if_b.Wash_done, if_b.Busy, prev_b);
        prev_b = if_b.Stage;
    end

    task automatic wait_until(input int c);
        while (g_cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d expected events still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic coin(input bit inst, input logic [1:0] passes, input logic [1:0] freq);
        if (inst) begin
            if_b.Coin_in = 1'b1; if_b.Wash_passes = passes; if_b.CLK_freq = freq;
        end else begin
            if_a.Coin_in = 1'b1; if_a.Wash_passes = passes; if_a.CLK_freq = freq;
        end
        @(posedge clk);
        #1;
        if_a.Coin_in = 1'b0;
        if_b.Coin_in = 1'b0;
    endtask

    initial begin
        if_a.Coin_in = 1'b0; if_a.Wash_passes = 2'd0; if_a.Timer_pause = 1'b0; if_a.CLK_freq = 2'd0;
        if_b.Coin_in = 1'b0; if_b.Wash_passes = 2'd0; if_b.Timer_pause = 1'b0; if_b.CLK_freq = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wash_done",  int'(if_a.Wash_done),  1);
        chk("rst_busy",       int'(if_a.Busy),       0);
        chk("rst_done_pulse", int'(if_a.Done_pulse), 0);
        chk("rst_stage",      int'(if_a.Stage),      0);
        chk("rst_pass_cnt",   int'(if_a.Pass_cnt),   0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single pass; a second coin during WASH must be ignored.
        c0 = g_cyc;
        push_seq(1'b0, c0, 1, 4, 0);
        coin(1'b0, 2'd1, 2'd0);
        wait_until(c0 + 12); if_a.Coin_in = 1'b1;
        wait_until(c0 + 13); if_a.Coin_in = 1'b0;
        drain(200);

        // Two passes: IDLE at cycle 61.
        c0 = g_cyc;
        push_seq(1'b0, c0, 2, 4, 0);
        coin(1'b0, 2'd2, 2'd0);
        drain(200);

        // Slowest-but-one prescale; a mid-WASH freq change has no effect.
        c0 = g_cyc;
        push_seq(1'b0, c0, 1, 16, 0);
        coin(1'b0, 2'd1, 2'd2);
        wait_until(c0 + 40); if_a.CLK_freq = 2'd0;
        drain(300);

        // Pause in WASH is ignored; 10-cycle pause from SPIN entry delays exit.
        c0 = g_cyc;
        push_seq(1'b0, c0, 1, 4, 10);
        coin(1'b0, 2'd1, 2'd0);
        wait_until(c0 + 12); if_a.Timer_pause = 1'b1;
        wait_until(c0 + 17); if_a.Timer_pause = 1'b0;
        wait_until(c0 + 29); if_a.Timer_pause = 1'b1;
        wait_until(c0 + 39); if_a.Timer_pause = 1'b0;
        drain(200);

        // Zero passes requested runs one pass.
        c0 = g_cyc;
        push_seq(1'b0, c0, 1, 4, 0);
        coin(1'b0, 2'd0, 2'd0);
        drain(200);

        // Three passes within the MAX_PASSES=3 limit.
        c0 = g_cyc;
        push_seq(1'b0, c0, 3, 4, 0);
        coin(1'b0, 2'd3, 2'd0);
        drain(300);

        // Three requested against MAX_PASSES=2 clamps to two.
        c0 = g_cyc;
        push_seq(1'b1, c0, 2, 4, 0);
        coin(1'b1, 2'd3, 2'd0);
        drain(300);

        // Reset during the second RINSE aborts straight to IDLE, no Done_pulse.
        c0 = g_cyc;
        push_one(1'b0, FILL,  0, 1'b0, c0 + 1);
        push_one(1'b0, WASH,  0, 1'b0, c0 + 9);
        push_one(1'b0, RINSE, 0, 1'b0, c0 + 21);
        push_one(1'b0, FILL,  1, 1'b0, c0 + 29);
        push_one(1'b0, WASH,  1, 1'b0, c0 + 37);
        push_one(1'b0, RINSE, 1, 1'b0, c0 + 49);
        push_one(1'b0, IDLE,  0, 1'b0, c0 + 52);
        coin(1'b0, 2'd2, 2'd0);
        wait_until(c0 + 52); rst_n = 1'b0;
        wait_until(c0 + 54); rst_n = 1'b1;
        drain(200);
        chk("post_reset_pass_cnt",  int'(if_a.Pass_cnt),  0);
        chk("post_reset_wash_done", int'(if_a.Wash_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
